axis_data_checker: RTL

- Sink stage directly downstream of the AXI-Stream test-pattern generator; consumes one frame and checks it beat by beat against the generator's pattern.
- Reports pass/fail, error count, first-error offset, byte and aborted-frame statistics.
- Used at RoCE loopback and receive endpoints for bring-up and regression.

---
 rtl/axis_data_checker.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/axis_data_checker.sv
// AXI-Stream frame checker: consumes one frame per arm request and compares each
// beat against the test-pattern generator's offset-based pattern and framing.
module axis_data_checker #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [31:0]             length,
  input  logic                    throttle,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [31:0]             error_count,
  output logic [31:0]             first_err_offset,
  output logic [31:0]             byte_count,
  output logic [15:0]             aborted_frames
);

  localparam int unsigned WORD_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned NSLICE     = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                    r_start_d;
  logic [31:0]             r_len;
  logic [31:0]             r_offset;
  logic                    r_abort;
  logic [31:0]             r_err_cnt;
  logic [31:0]             r_first_err;
  logic [31:0]             r_byte_cnt;
  logic [15:0]             r_aborted;
  logic                    r_pass;
  logic                    r_done;

  logic                    w_arm;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_exp_data;
  logic [DATA_WIDTH/8-1:0] w_exp_keep;
  logic [32:0]             w_off_end;
  logic                    w_exp_last;
  logic                    w_overrun;
  logic [31:0]             w_rem;
  logic                    w_data_mis;
  logic                    w_abort_now;
  logic                    w_bad;
  logic [31:0]             w_keep_cnt;
  logic [31:0]             w_err_next;

  assign w_arm    = start & ~r_start_d & (length != '0) & (r_state != S_RUN);
  assign w_accept = s_axis_tvalid & s_axis_tready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_arm) w_state_nxt = S_RUN;
      S_RUN:          if (w_accept && s_axis_tlast) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    if (r_state == S_RUN) begin
      s_axis_tready = ~throttle;
      busy          = 1'b1;
    end
  end

  always_comb begin
    w_exp_data = '0;
    for (int unsigned s = 0; s < NSLICE; s++) begin
      if (s == 0)      w_exp_data[32*s +: 32] = r_offset;
      else if (s == 1) w_exp_data[32*s +: 32] = ~r_offset;
      else             w_exp_data[32*s +: 32] = 32'hDEADBEEF;
    end
  end

  // Framing expectation; the 33-bit end offset keeps exp_last correct near 2^32.
  assign w_off_end  = {1'b0, r_offset} + 33'(WORD_WIDTH);
  assign w_exp_last = (w_off_end >= {1'b0, r_len});
  assign w_overrun  = (r_offset >= r_len);
  assign w_rem      = r_len - r_offset;

  always_comb begin
    w_exp_keep = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      w_exp_keep[i] = ~w_exp_last | (w_rem > i);
    end
  end

  always_comb begin
    w_data_mis = 1'b0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != w_exp_data[8*i +: 8])) begin
        w_data_mis = 1'b1;
      end
    end
  end

  always_comb begin
    w_keep_cnt = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      w_keep_cnt = w_keep_cnt + {31'd0, s_axis_tkeep[i]};
    end
  end

  // Beats past the expected end are always bad, so a missing tlast keeps counting.
  assign w_abort_now = r_abort | s_axis_tuser;
  assign w_bad       = ~w_abort_now &
                       (w_overrun | w_data_mis |
                        (s_axis_tkeep != w_exp_keep) |
                        (s_axis_tlast != w_exp_last));

  always_comb begin
    w_err_next = r_err_cnt;
    if (w_bad && (r_err_cnt != '1)) begin
      w_err_next = r_err_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d   <= 1'b0;
      r_len       <= '0;
      r_offset    <= '0;
      r_abort     <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '1;
      r_byte_cnt  <= '0;
      r_aborted   <= '0;
      r_pass      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start_d <= start;
      r_done    <= (r_state == S_RUN) & w_accept & s_axis_tlast;
      if (w_arm) begin
        r_len       <= length;
        r_offset    <= '0;
        r_abort     <= 1'b0;
        r_err_cnt   <= '0;
        r_first_err <= '1;
        r_byte_cnt  <= '0;
        r_pass      <= 1'b0;
      end else if ((r_state == S_RUN) && w_accept) begin
        r_offset   <= r_offset + 32'(WORD_WIDTH);
        r_byte_cnt <= r_byte_cnt + w_keep_cnt;
        r_err_cnt  <= w_err_next;
        r_abort    <= w_abort_now;
        if (w_bad && (r_first_err == '1)) begin
          r_first_err <= r_offset;
        end
        if (s_axis_tlast) begin
          r_pass    <= (w_err_next == '0) & ~w_abort_now;
          r_aborted <= r_aborted + {15'd0, w_abort_now};
        end
      end
    end
  end

  assign done             = r_done;
  assign pass             = r_pass;
  assign error_count      = r_err_cnt;
  assign first_err_offset = r_first_err;
  assign byte_count       = r_byte_cnt;
  assign aborted_frames   = r_aborted;

endmodule
